// File: rtl/rom_if_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rom_if_pkg
// Purpose  : Shared widths and fetch-controller state encoding for the
//            synchronous 4-bit ROM port.
// Revision : 1.0 - initial release
// ============================================================================
package rom_if_pkg;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage : rom_if_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with occupancy count. Push and pop in the same
//            cycle leave the count unchanged. DEPTH must be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Guard against pop-when-empty and push-when-full so pointers never skew.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_C) || do_pop);

  // Storage array: written on push, no reset needed (head is qualified by count).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/rom_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rom_fetch_ctrl
// Purpose  : Issues a burst of sequential ROM reads, captures each word after
//            the ROM's one-cycle latency and streams it out over valid/ready
//            with a last marker. Issue is throttled so the capture FIFO can
//            never overflow.
// Revision : 1.0 - initial release
// ============================================================================
module rom_fetch_ctrl
  import rom_if_pkg::*;
#(
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int DATA_W     = ROM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W:0]   issued_q, issued_d;   // one extra bit so 16 reads fit
  logic              pend_q;               // a read was issued last cycle
  logic              pend_last_q;          // ...and it was the final read
  logic              is_final;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic [DATA_W:0]   fifo_rdata;
  logic              fifo_pop;

  // Slots already used plus the word still in flight from the ROM.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_q};
  assign is_final  = (issued_q == {1'b0, len_q});

  // Next-state, read issue and completion decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    rom_en_o = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = FETCH;
          addr_d   = base_addr_i;
          len_d    = len_i;
          issued_d = '0;
        end
      end
      FETCH: begin
        if (occupancy < DEPTH_C) begin
          rom_en_o = 1'b1;
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + (ADDR_W+1)'(1);
          if (is_final) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && fifo_rdata[DATA_W]) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and burst bookkeeping registers; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      pend_q      <= rom_en_o;
      pend_last_q <= rom_en_o && is_final;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pend_q),
    .wdata_i ({pend_last_q, rom_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign rom_addr_o  = addr_q;
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (fifo_count != '0);
  assign fifo_pop    = out_valid_o && out_ready_i;
  // Head is qualified by valid so idle/reset outputs read as zero.
  assign out_data_o  = out_valid_o ? fifo_rdata[DATA_W-1:0] : '0;
  assign out_last_o  = out_valid_o && fifo_rdata[DATA_W];

endmodule : rom_fetch_ctrl
`default_nettype wire

// File: tb/tb_rom_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rom_fetch_ctrl
// Purpose  : Self-checking bench for rom_fetch_ctrl with a ROM model
//            (word = ~addr) and address/data scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [3:0] len;
  logic       busy, done, rom_en, out_valid, out_ready, out_last;
  logic [3:0] rom_addr, rom_data, out_data;

  int n_chk = 0;
  int n_err = 0;
  int en_cnt = 0;
  int words_cnt = 0;

  logic [4:0] exp_q [$];      // {last, data}
  logic [3:0] addr_exp_q [$];

  logic       hold_q = 1'b0;
  logic [4:0] hold_val = '0;

  always #5 clk = ~clk;

  rom_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .rom_en_o    (rom_en),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

  // ROM model: one-cycle read latency, contents are the inverted address.
  always @(posedge clk) begin
    if (rom_en) rom_data <= ~rom_addr;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: address stream, output stream, hold-stability and done alignment.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_en) begin
        en_cnt++;
        if (addr_exp_q.size() == 0) check_eq("rom_en_extra", 32'(1), 32'(0));
        else check_eq("rom_addr", 32'(rom_addr), 32'(addr_exp_q.pop_front()));
      end
      if (hold_q && out_valid) check_eq("hold_stable", 32'({out_last, out_data}), 32'(hold_val));
      if (out_valid && out_ready) begin
        logic [4:0] e;
        words_cnt++;
        if (exp_q.size() == 0) check_eq("out_extra", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          check_eq("out_data", 32'(out_data), 32'(e[3:0]));
          check_eq("out_last", 32'(out_last), 32'(e[4]));
          check_eq("done_on_last", 32'(done), 32'(e[4]));
        end
      end
      hold_q   = out_valid && !out_ready;
      hold_val = {out_last, out_data};
    end else begin
      hold_q = 1'b0;
    end
  end

  task automatic start_burst(input logic [3:0] b, input logic [3:0] l);
    logic [3:0] a;
    for (int i = 0; i <= int'(l); i++) begin
      a = b + 4'(i);
      addr_exp_q.push_back(a);
      exp_q.push_back({(i == int'(l)), ~a});
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_c1", 32'(busy), 32'(1));
    check_eq("rom_en_c1", 32'(rom_en), 32'(1));
    check_eq("rom_addr_c1", 32'(rom_addr), 32'(b));
  endtask

  // Called in cycle 1 of a burst; counts cycles until the first word appears.
  task automatic check_latency();
    int k = 1;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("first_latency", 32'(k), 32'(3));
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("done_seen", 32'(done), 32'(1));
    @(posedge clk); #1;
    check_eq("busy_after", 32'(busy), 32'(0));
    check_eq("done_pulse", 32'(done), 32'(0));
    check_eq("sb_empty", 32'(exp_q.size() + addr_exp_q.size()), 32'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"},      32'(busy),      32'(0));
    check_eq({tag, "_done"},      32'(done),      32'(0));
    check_eq({tag, "_rom_en"},    32'(rom_en),    32'(0));
    check_eq({tag, "_rom_addr"},  32'(rom_addr),  32'(0));
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check_eq({tag, "_out_data"},  32'(out_data),  32'(0));
    check_eq({tag, "_out_last"},  32'(out_last),  32'(0));
  endtask

  initial begin
    int e0, w0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Basic burst: 0xD, 0xC, 0xB, 0xA with last/done on the final word.
    start_burst(4'd2, 4'd3);
    check_latency();
    wait_done();

    // Address wrap-around: 14, 15, 0, 1.
    start_burst(4'd14, 4'd3);
    wait_done();

    // Full 16-word range.
    w0 = words_cnt;
    start_burst(4'd0, 4'd15);
    wait_done();
    check_eq("full_words", 32'(words_cnt - w0), 32'(16));

    // Backpressure: ready low for 10 cycles, issue must stall at FIFO depth.
    out_ready = 1'b0;
    e0 = en_cnt;
    start_burst(4'd5, 4'd7);
    repeat (9) begin @(posedge clk); #1; end
    check_eq("bp_en_max4", 32'(en_cnt - e0 <= 4), 32'(1));
    check_eq("bp_valid", 32'(out_valid), 32'(1));
    check_eq("bp_rom_en_off", 32'(rom_en), 32'(0));
    out_ready = 1'b1;
    wait_done();

    // Start while busy must be ignored.
    start_burst(4'd3, 4'd7);
    start = 1'b1; base_addr = 4'd9; len = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (3) begin @(posedge clk); #1; end
    check_eq("idle_rom_en", 32'(rom_en), 32'(0));

    // Reset mid-burst, then a cold single-word burst.
    start_burst(4'd5, 4'd7);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    addr_exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_burst(4'd0, 4'd0);
    check_latency();
    check_eq("cold_data", 32'(out_data), 32'(4'hF));
    check_eq("cold_last", 32'(out_last), 32'(1));
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_rom_fetch_ctrl
`default_nettype wire

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Initiator-side controller for the synchronous 4-bit ROM port (clk / en / addr / data). On a start command it issues a burst of sequential ROM reads from a base address. It captures each returned word after the ROM's one-cycle read latency and delivers the words downstream over a valid/ready stream with backpressure. It sits between the sequencing logic that wants a block of constants and the ROM macro.

## Interface
- ADDR_W, 4, ROM address width; address space is 2^ADDR_W words
- DATA_W, 4, ROM word width
- FIFO_DEPTH, 4, capture buffer entries; power of two, minimum 2
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  burst request; sampled only in IDLE
- base_addr  in  ADDR_W  first ROM address of the burst; sampled with start
- len  in  ADDR_W  burst length minus one (0 → 1 word, 15 → 16 words)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word is accepted downstream
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM read address
- rom_data  in  DATA_W  ROM read data; valid one cycle after rom_en
- out_valid  out  1  out_data holds a word
- out_ready  in  1  downstream accepts the word when valid && ready
- out_data  out  DATA_W  head word of the FIFO
- out_last  out  1  marks the final word of the burst

## Operation
- States:
  - IDLE → FETCH on start.
  - FETCH → DRAIN after the final read is issued.
  - DRAIN → IDLE when the last word is accepted; done pulses on that cycle.
- start while busy is ignored; no queueing.
- Issue rule in FETCH: rom_en=1 when fifo_count + pend < FIFO_DEPTH. pend is 1 if rom_en was high in the previous cycle.
- rom_addr: starts at base_addr and increments modulo 2^ADDR_W per issued read. Wrap-around is legal (base 14, len 3 reads 14, 15, 0, 1).
- Capture: when pend=1, rom_data is written into the FIFO at the end of that cycle. Overflow is impossible by the issue rule.
- Issue counter: ADDR_W+1 bits, so that 16 reads can be counted.
- out_last: travels as a FIFO side bit, set on the entry for read index len.
- FIFO: simultaneous push and pop in one cycle is allowed; the count is unchanged.
- Reset, including mid-burst:
  - FSM returns to IDLE, FIFO is emptied, pend is cleared.
  - Outputs busy, done, rom_en, out_valid, out_last = 0; rom_addr, out_data = 0.
  - Any in-flight ROM word is discarded.

## Timing
- start sampled at edge E0 → busy=1 and rom_en=1 with rom_addr=base_addr in cycle 1.
- ROM output is valid in cycle 2 and written at E2, so out_valid=1 in cycle 3. First-word latency is 3 cycles.
- With out_ready held high: one word per cycle, and rom_en stays high continuously.
- With out_ready low: rom_en drops once fifo_count + pend reaches FIFO_DEPTH. Issuing resumes the cycle after a pop frees a slot.
- out_data and out_last are stable while out_valid && !out_ready.
- done and busy deassert at the same edge: the one after the last handshake.
- A new start is accepted in the cycle following done.

## Structure
- Shared package `rom_if_pkg`: ADDR_W/DATA_W defaults and the FSM state enum (IDLE, FETCH, DRAIN).
- Sub-module `sync_fifo`: parameterised width (DATA_W+1, carrying the last flag) and depth, with count output. Instantiated once.

## Test plan
- Reset mid-burst:
  - Stimulus: drive rst_n low for 1 cycle during FETCH.
  - Required: all outputs return to 0 immediately; the next start (base 0, len 0) behaves as from cold.
- Basic burst with a ROM model (word = ~addr):
  - Stimulus: start, base 2, len 3, out_ready=1.
  - Required: out_data 0xD, 0xC, 0xB, 0xA on consecutive cycles starting cycle 3; out_last only on 0xA; done pulse on the same cycle.
- Wrap-around:
  - Stimulus: base 14, len 3.
  - Required: rom_addr sequence 14, 15, 0, 1.
- Full-range burst:
  - Stimulus: base 0, len 15.
  - Required: exactly 16 words; busy low afterwards.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after start (len 7).
  - Required: at most 4 rom_en pulses; out_data held; all 8 words delivered in order once ready=1.
- Start while busy:
  - Stimulus: second start with base 9 mid-burst.
  - Required: ignored; original sequence unaffected.
